execute: RTL

EXECUTE -- requirements
Module: execute

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/execute_multdiv.sv | 105 ++++++++++
 rtl/execute.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: opcodes, ALU operations,
// the mul/div FSM state type and the iterative mul/div datapath word.
package cpu_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_t;

  // acc: product accumulator / division remainder
  // q:   multiplier shifting right / dividend shifting into quotient
  // m:   multiplicand shifting left / divisor magnitude
  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] q;
    logic [31:0] m;
  } md_dp_t;

endpackage

// File: rtl/execute_multdiv.sv
// Iterative 32-step multiplier / restoring divider with IDLE->BUSY->DONE FSM.
// Only instantiated by execute when EXECUTE_MULTDIV_EN is defined.
module multdiv
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_result
);

  md_state_t   r_state;
  md_state_t   w_next;
  logic [4:0]  r_cnt;
  md_dp_t      r_dp;
  md_dp_t      w_init;
  logic        r_div;
  logic        r_neg;
  logic        r_zero;
  logic        w_start;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic md_dp_t mul_step(input md_dp_t s);
    md_dp_t n;
    n.acc = s.q[0] ? (s.acc + s.m) : s.acc;
    n.q   = s.q >> 1;
    n.m   = s.m << 1;
    return n;
  endfunction

  function automatic md_dp_t div_step(input md_dp_t s);
    md_dp_t      n;
    logic [32:0] w_rem;
    w_rem = {1'b0, s.acc[31:0]} << 1;
    w_rem[0] = s.q[31];
    n.m = s.m;
    if (w_rem >= {1'b0, s.m}) begin
      w_rem = w_rem - {1'b0, s.m};
      n.q   = {s.q[30:0], 1'b1};
    end else begin
      n.q   = {s.q[30:0], 1'b0};
    end
    n.acc = w_rem[31:0];
    return n;
  endfunction

  assign w_start = (r_state == ST_IDLE) && i_req;

  always_comb begin
    w_init.acc = '0;
    w_init.q   = i_div ? mag(i_a) : i_b;
    w_init.m   = i_div ? mag(i_b) : i_a;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_req) w_next = ST_BUSY;
      ST_BUSY: if (r_cnt == 5'd31) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The capture edge performs step 0; BUSY edges with counter 1..31 finish the rest.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start)
        r_cnt <= 5'd1;
      else if (r_state == ST_BUSY)
        r_cnt <= r_cnt + 5'd1;
      else
        r_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_start) begin
      r_dp   <= i_div ? div_step(w_init) : mul_step(w_init);
      r_div  <= i_div;
      r_neg  <= i_a[31] ^ i_b[31];
      r_zero <= (i_b == 32'd0);
    end else if (r_state == ST_BUSY) begin
      r_dp <= r_div ? div_step(r_dp) : mul_step(r_dp);
    end
  end

  assign o_stall  = ~reset & (w_start | (r_state == ST_BUSY));
  assign o_done   = ~reset & (r_state == ST_DONE);
  assign o_result = r_div ? (r_zero ? 32'd0 : (r_neg ? (~r_dp.q + 32'd1) : r_dp.q))
                          : r_dp.acc;

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, branch resolution and the output pipeline register.
// Define EXECUTE_MULTDIV_EN to include the multi-cycle mul/div unit.
module execute
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] num_a,
  input  logic [31:0] num_b,
  input  logic [31:0] data_cmp,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rd,
  input  logic [11:0] pc,
  input  logic        nop,
  input  logic        en,
  input  logic        mwen,
  input  logic        lw,
  output logic [31:0] out_result,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_nop,
  output logic        out_en,
  output logic        out_mwen,
  output logic        out_lw,
  output logic        branch_taken,
  output logic [11:0] branch_target,
  output logic        stall
);

  logic signed [31:0] w_a_s;
  logic signed [31:0] w_cmp_s;
  logic [31:0]        w_alu;
  logic [31:0]        w_result;
  logic [31:0]        w_md_result;
  logic               w_md_op;
  logic               w_md_done;
  logic               w_is_branch;
  logic               w_bubble;

  assign w_a_s   = num_a;
  assign w_cmp_s = data_cmp;

  always_comb begin
    w_alu   = num_a + num_b;
    w_md_op = 1'b0;
    case (opcode)
      OP_ALU: begin
        case (aluop)
          ALU_ADD: w_alu = num_a + num_b;
          ALU_SUB: w_alu = num_a - num_b;
          ALU_AND: w_alu = num_a & num_b;
          ALU_OR:  w_alu = num_a | num_b;
          ALU_SLL: w_alu = num_a << shamt;
          ALU_SRA: w_alu = w_a_s >>> shamt;
          ALU_MUL, ALU_DIV: w_md_op = 1'b1;
          default: w_alu = num_a + num_b;
        endcase
      end
      OP_ADDI, OP_SW, OP_LW: w_alu = num_a + num_b;
      default: w_alu = num_a + num_b;
    endcase
  end

  assign w_is_branch   = (opcode == OP_BNE) || (opcode == OP_BLT);
  assign branch_taken  = ~reset & ~nop &
                         (((opcode == OP_BNE) & (num_a != data_cmp)) |
                          ((opcode == OP_BLT) & (w_a_s < w_cmp_s)));
  assign branch_target = pc + 12'd1 + num_b[11:0];

`ifdef EXECUTE_MULTDIV_EN
  multdiv u_multdiv (
    .clock    (clock),
    .reset    (reset),
    .i_req    (w_md_op & ~nop),
    .i_div    (aluop == ALU_DIV),
    .i_a      (num_a),
    .i_b      (num_b),
    .o_stall  (stall),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );
`else
  assign stall       = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  // In DONE the held mul/div instruction is still on the inputs, so its sideband is current.
  assign w_result = w_md_done ? w_md_result : w_alu;
  assign w_bubble = nop | w_is_branch | stall | (w_md_op & ~w_md_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_result <= '0;
      out_b      <= '0;
      out_rd     <= '0;
      out_nop    <= 1'b1;
      out_en     <= 1'b0;
      out_mwen   <= 1'b0;
      out_lw     <= 1'b0;
    end else begin
      out_result <= w_result;
      out_b      <= data_cmp;
      out_rd     <= rd;
      out_nop    <= w_bubble;
      out_en     <= en & ~w_bubble;
      out_mwen   <= mwen & ~w_bubble;
      out_lw     <= lw & ~w_bubble;
    end
  end

endmodule
